// File: rtl/vmicro16_apb_master_if.sv
// Core request/response and APB master signals for the vmicro16 APB bridge.
interface vmicro16_apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);

  // Core side: single-outstanding request, one-cycle response pulse
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  // APB side toward the peripheral interconnect
  logic [ADDR_WIDTH-1:0] M_PADDR;
  logic                  M_PWRITE;
  logic                  M_PSELx;
  logic                  M_PENABLE;
  logic [DATA_WIDTH-1:0] M_PWDATA;
  logic [DATA_WIDTH-1:0] M_PRDATA;
  logic                  M_PREADY;

  // Bridge view
  modport master (
    input  req_valid, req_addr, req_wdata, req_we, M_PRDATA, M_PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

  // Environment view (core + APB slave)
  modport slave (
    output req_valid, req_addr, req_wdata, req_we, M_PRDATA, M_PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

endinterface

// File: rtl/vmicro16_apb_master.sv
// vmicro16 APB master bridge: turns a core valid/ready request into one APB
// SETUP/ACCESS transfer, with a bounded wait-state timeout that aborts a hung
// slave and returns an error response instead of deadlocking the core.
module vmicro16_apb_master #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  vmicro16_apb_master_if.master bus
);

  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // State and datapath registers; async reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d  = ST_SETUP;
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pwrite_d = bus.req_we;
          psel_d   = 1'b1;
        end
      end

      ST_SETUP: begin
        // PREADY is not looked at during SETUP
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        if (bus.M_PREADY || (TO_EN && (cnt_q == CNT_LAST))) begin
          // Completion and abort both return to IDLE with the bus parked at 0;
          // PREADY wins when it coincides with the last allowed wait cycle.
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          pwrite_d    = 1'b0;
          if (bus.M_PREADY) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = pwrite_q ? '0 : bus.M_PRDATA;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs come straight from registers or the state register
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.M_PADDR   = paddr_q;
  assign bus.M_PWDATA  = pwdata_q;
  assign bus.M_PWRITE  = pwrite_q;
  assign bus.M_PSELx   = psel_q;
  assign bus.M_PENABLE = penable_q;

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Self-checking bench for vmicro16_apb_master (TIMEOUT = 4).
module tb_vmicro16_apb_master;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 16;
  localparam int unsigned TO  = 4;
  localparam int          WIN = int'(TO) + 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the held response data register
  logic [DW-1:0] last_rdata = '0;

  vmicro16_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vmicro16_apb_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          accept_ready;
    logic          setup_psel;
    logic          setup_penable;
    logic          setup_pwrite;
    logic          setup_ready;
    logic          setup_busy;
    logic [AW-1:0] setup_paddr;
    logic [DW-1:0] setup_pwdata;
    logic [DW-1:0] setup_rdata;
    int            n_access;
    bit            stable;
    int            early_ready;
    int            rsp_cyc;
    int            n_rsp;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_bus_active;
    logic          rsp_ready;
    logic [DW-1:0] tail_rdata;
    logic          tail_psel;
  } obs_t;

  typedef struct {
    int            n_acc;
    int            rsp_c;
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;

  // Transaction-level reference: slave stalls `waits` cycles, then answers
  function automatic exp_t model_txn(input logic we, input int waits, input logic [DW-1:0] prd);
    exp_t e;
    if (TO != 0 && waits >= int'(TO)) begin
      e.n_acc = int'(TO);
      e.err   = 1'b1;
      e.rd    = '0;
    end else begin
      e.n_acc = waits + 1;
      e.err   = 1'b0;
      e.rd    = we ? '0 : prd;
    end
    e.rsp_c = e.n_acc + 2;  // SETUP is cycle 1, response the cycle after ACCESS ends
    return e;
  endfunction

  // Issue one request and act as an APB slave; records what the DUT did.
  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                         input int waits, input logic [DW-1:0] prd, output obs_t o);
    int acc_idx;
    o.accept_ready = 1'b0; o.setup_psel = 1'b0; o.setup_penable = 1'b0; o.setup_pwrite = 1'b0;
    o.setup_ready = 1'b0; o.setup_busy = 1'b0; o.setup_paddr = '0; o.setup_pwdata = '0;
    o.setup_rdata = '0; o.n_access = 0; o.stable = 1'b1; o.early_ready = 0; o.rsp_cyc = -1;
    o.n_rsp = 0; o.rsp_err = 1'b0; o.rsp_rdata = '0; o.rsp_bus_active = 1'b0; o.rsp_ready = 1'b0;
    o.tail_rdata = '0; o.tail_psel = 1'b0;
    acc_idx = 0;

    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_we    = we;
    bus.M_PREADY  = 1'b0;
    @(negedge clk);
    o.accept_ready = bus.req_ready;
    @(posedge clk); #1;
    // Scramble the request lines; the transfer in flight must ignore them
    bus.req_valid = 1'b0;
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    bus.req_we    = ~we;

    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (c == 1) begin
        o.setup_psel    = bus.M_PSELx;
        o.setup_penable = bus.M_PENABLE;
        o.setup_pwrite  = bus.M_PWRITE;
        o.setup_paddr   = bus.M_PADDR;
        o.setup_pwdata  = bus.M_PWDATA;
        o.setup_ready   = bus.req_ready;
        o.setup_busy    = bus.busy;
        o.setup_rdata   = bus.rsp_rdata;
      end
      if (bus.M_PSELx && bus.M_PENABLE) begin
        o.n_access++;
        if (bus.M_PADDR !== o.setup_paddr || bus.M_PWDATA !== o.setup_pwdata ||
            bus.M_PWRITE !== o.setup_pwrite)
          o.stable = 1'b0;
        bus.M_PREADY = (acc_idx == waits);
        bus.M_PRDATA = (acc_idx == waits) ? prd : DW'($urandom);
        acc_idx++;
      end else begin
        // Outside ACCESS the slave keeps PREADY high: must be ignored
        bus.M_PREADY = 1'b1;
        bus.M_PRDATA = DW'($urandom);
      end
      if (bus.rsp_valid) begin
        o.n_rsp++;
        if (o.rsp_cyc < 0) begin
          o.rsp_cyc        = c;
          o.rsp_err        = bus.rsp_err;
          o.rsp_rdata      = bus.rsp_rdata;
          o.rsp_bus_active = bus.M_PSELx | bus.M_PENABLE;
          o.rsp_ready      = bus.req_ready;
        end
      end else if (o.rsp_cyc < 0 && bus.req_ready) begin
        o.early_ready++;
      end
      if (c == WIN) begin
        o.tail_rdata = bus.rsp_rdata;
        o.tail_psel  = bus.M_PSELx;
      end
      @(posedge clk); #1;
    end
    bus.M_PREADY = 1'b0;
  endtask

  task automatic test_reset();
    string nm [9] = '{"busy", "psel", "penable", "paddr", "pwdata", "pwrite", "rsp_valid", "rsp_err", "rsp_rdata"};
    logic [31:0] got [9];
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = '{32'(bus.busy), 32'(bus.M_PSELx), 32'(bus.M_PENABLE), 32'(bus.M_PADDR), 32'(bus.M_PWDATA),
            32'(bus.M_PWRITE), 32'(bus.rsp_valid), 32'(bus.rsp_err), 32'(bus.rsp_rdata)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset.%s: got 0x%0h, expected 0x0", nm[i], got[i]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    last_rdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_write();
    obs_t o; exp_t e;
    string nm [15] = '{"accept_ready", "setup_psel", "setup_penable", "setup_paddr", "setup_pwdata",
                       "setup_pwrite", "setup_ready", "setup_busy", "n_access", "rsp_cycle",
                       "rsp_count", "rsp_err", "rsp_rdata", "rsp_ready", "rsp_bus_active"};
    logic [31:0] got [15];
    logic [31:0] want [15];
    e = model_txn(1'b1, 0, 16'h0);
    run_txn(20'h00012, 16'hBEEF, 1'b1, 0, DW'($urandom), o);
    got  = '{32'(o.accept_ready), 32'(o.setup_psel), 32'(o.setup_penable), 32'(o.setup_paddr),
             32'(o.setup_pwdata), 32'(o.setup_pwrite), 32'(o.setup_ready), 32'(o.setup_busy),
             32'(o.n_access), 32'(o.rsp_cyc), 32'(o.n_rsp), 32'(o.rsp_err), 32'(o.rsp_rdata),
             32'(o.rsp_ready), 32'(o.rsp_bus_active)};
    want = '{32'h1, 32'h1, 32'h0, 32'h00012, 32'hBEEF, 32'h1, 32'h0, 32'h1,
             32'(e.n_acc), 32'(e.rsp_c), 32'h1, 32'(e.err), 32'(e.rd), 32'h1, 32'h0};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL zero_wait_write.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = e.rd;
  endtask

  task automatic test_wait_read();
    obs_t o; exp_t e;
    logic [AW-1:0] a;
    string nm [9] = '{"setup_paddr", "setup_pwrite", "stable", "n_access", "early_ready",
                      "rsp_cycle", "rsp_err", "rsp_rdata", "tail_rdata"};
    logic [31:0] got [9];
    logic [31:0] want [9];
    a = AW'($urandom);
    e = model_txn(1'b0, 3, 16'h1234);
    run_txn(a, DW'($urandom), 1'b0, 3, 16'h1234, o);
    got  = '{32'(o.setup_paddr), 32'(o.setup_pwrite), 32'(o.stable), 32'(o.n_access), 32'(o.early_ready),
             32'(o.rsp_cyc), 32'(o.rsp_err), 32'(o.rsp_rdata), 32'(o.tail_rdata)};
    want = '{32'(a), 32'h0, 32'h1, 32'(e.n_acc), 32'h0, 32'(e.rsp_c), 32'(e.err), 32'(e.rd), 32'(e.rd)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL wait_read.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = e.rd;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    string nm [8] = '{"n_access", "rsp_cycle", "rsp_count", "rsp_err", "rsp_rdata",
                      "rsp_bus_active", "tail_psel", "setup_rdata_held"};
    logic [31:0] got [8];
    logic [31:0] want [8];
    e = model_txn(1'b0, 1000, 16'h0);
    run_txn(AW'($urandom), DW'($urandom), 1'b0, 1000, DW'($urandom), o);
    got  = '{32'(o.n_access), 32'(o.rsp_cyc), 32'(o.n_rsp), 32'(o.rsp_err), 32'(o.rsp_rdata),
             32'(o.rsp_bus_active), 32'(o.tail_psel), 32'(o.setup_rdata)};
    want = '{32'(e.n_acc), 32'(e.rsp_c), 32'h1, 32'(e.err), 32'(e.rd), 32'h0, 32'h0, 32'(last_rdata)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL timeout.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = e.rd;
  endtask

  task automatic test_timeout_boundary();
    obs_t o; exp_t e;
    string nm [5] = '{"n_access", "rsp_cycle", "rsp_count", "rsp_err", "rsp_rdata"};
    logic [31:0] got [5];
    logic [31:0] want [5];
    e = model_txn(1'b0, int'(TO) - 1, 16'h00AA);
    run_txn(AW'($urandom), DW'($urandom), 1'b0, int'(TO) - 1, 16'h00AA, o);
    got  = '{32'(o.n_access), 32'(o.rsp_cyc), 32'(o.n_rsp), 32'(o.rsp_err), 32'(o.rsp_rdata)};
    want = '{32'(e.n_acc), 32'(e.rsp_c), 32'h1, 32'(e.err), 32'(e.rd)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL timeout_boundary.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = e.rd;
  endtask

  task automatic test_back_to_back();
    logic [8:0] ready_v, rsp_v, psel_v;
    logic [AW-1:0] paddr_c1, paddr_c4;
    logic [DW-1:0] rdata_c3, rdata_c6, prd1, prd2;
    string nm [7] = '{"req_ready_pattern", "rsp_valid_pattern", "psel_pattern",
                      "setup1_paddr", "setup2_paddr", "rsp1_rdata", "rsp2_rdata"};
    logic [31:0] got [7];
    logic [31:0] want [7];
    ready_v = '0; rsp_v = '0; psel_v = '0;
    paddr_c1 = '0; paddr_c4 = '0; rdata_c3 = '0; rdata_c6 = '0;
    prd1 = DW'($urandom);
    prd2 = DW'($urandom);
    bus.req_valid = 1'b1;
    bus.req_addr  = 20'h00001;
    bus.req_we    = 1'b0;
    bus.req_wdata = DW'($urandom);
    bus.M_PREADY  = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ready_v[c] = bus.req_ready;
      rsp_v[c]   = bus.rsp_valid;
      psel_v[c]  = bus.M_PSELx;
      if (c == 1) paddr_c1 = bus.M_PADDR;
      if (c == 4) paddr_c4 = bus.M_PADDR;
      if (c == 3) rdata_c3 = bus.rsp_rdata;
      if (c == 6) rdata_c6 = bus.rsp_rdata;
      if (bus.M_PSELx && bus.M_PENABLE) begin
        bus.M_PREADY = 1'b1;
        bus.M_PRDATA = (bus.M_PADDR == 20'h00001) ? prd1 : prd2;
      end else begin
        bus.M_PREADY = 1'b0;
        bus.M_PRDATA = DW'($urandom);
      end
      @(posedge clk); #1;
      if (c == 0) bus.req_addr = 20'h00002;
      if (c == 3) bus.req_valid = 1'b0;
    end
    bus.M_PREADY = 1'b0;
    got  = '{32'(ready_v), 32'(rsp_v), 32'(psel_v), 32'(paddr_c1), 32'(paddr_c4), 32'(rdata_c3), 32'(rdata_c6)};
    want = '{32'b1_1100_1001, 32'b0_0100_1000, 32'b0_0011_0110, 32'h1, 32'h2, 32'(prd1), 32'(prd2)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL back_to_back.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = prd2;
  endtask

  task automatic test_reset_mid_access();
    obs_t o; exp_t e;
    int rsp_seen;
    logic [AW-1:0] a;
    string nm [11] = '{"in_access", "psel", "penable", "paddr", "pwdata", "busy", "rsp_valid",
                       "rsp_after_reset", "rsp_rdata_cleared", "post_rsp_cycle", "post_rsp_err"};
    logic [31:0] got [11];
    logic [31:0] want [11];
    logic pre_en;
    rsp_seen = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 20'h80000 | AW'($urandom);
    bus.req_wdata = 16'h8000 | DW'($urandom);
    bus.req_we    = 1'b1;
    bus.M_PREADY  = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    pre_en = bus.M_PENABLE;
    reset = 1'b0;
    #1;
    got[0] = 32'(pre_en);        got[1] = 32'(bus.M_PSELx); got[2] = 32'(bus.M_PENABLE);
    got[3] = 32'(bus.M_PADDR);   got[4] = 32'(bus.M_PWDATA); got[5] = 32'(bus.busy);
    got[6] = 32'(bus.rsp_valid);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.M_PREADY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
      @(posedge clk); #1;
    end
    bus.M_PREADY = 1'b0;
    got[7] = 32'(rsp_seen);
    got[8] = 32'(bus.rsp_rdata);
    last_rdata = '0;
    a = AW'($urandom);
    e = model_txn(1'b1, 0, 16'h0);
    run_txn(a, DW'($urandom), 1'b1, 0, DW'($urandom), o);
    got[9]  = 32'(o.rsp_cyc);
    got[10] = 32'(o.rsp_err);
    want = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'(e.rsp_c), 32'(e.err)};
    foreach (nm[i]) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL reset_mid_access.%s: got 0x%0h, expected 0x%0h", nm[i], got[i], want[i]);
      end
    end
    last_rdata = e.rd;
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [AW-1:0] a; logic [DW-1:0] d, prd; logic we; int waits;
    string nm [11] = '{"setup_paddr", "setup_pwdata", "setup_pwrite", "stable", "n_access", "rsp_cycle",
                       "rsp_count", "rsp_err", "rsp_rdata", "setup_rdata_held", "tail_rdata"};
    logic [31:0] got [11];
    logic [31:0] want [11];
    for (int t = 0; t < 24; t++) begin
      a     = AW'($urandom);
      d     = DW'($urandom);
      prd   = DW'($urandom);
      we    = 1'($urandom);
      waits = int'($urandom_range(0, 6));
      e = model_txn(we, waits, prd);
      run_txn(a, d, we, waits, prd, o);
      got  = '{32'(o.setup_paddr), 32'(o.setup_pwdata), 32'(o.setup_pwrite), 32'(o.stable),
               32'(o.n_access), 32'(o.rsp_cyc), 32'(o.n_rsp), 32'(o.rsp_err), 32'(o.rsp_rdata),
               32'(o.setup_rdata), 32'(o.tail_rdata)};
      want = '{32'(a), 32'(d), 32'(we), 32'h1, 32'(e.n_acc), 32'(e.rsp_c), 32'h1,
               32'(e.err), 32'(e.rd), 32'(last_rdata), 32'(e.rd)};
      foreach (nm[i]) begin
        n_checks++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL random[%0d].%s: got 0x%0h, expected 0x%0h (we=%0d waits=%0d)",
                   t, nm[i], got[i], want[i], we, waits);
        end
      end
      last_rdata = e.rd;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.M_PRDATA  = '0;
    bus.M_PREADY  = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vmicro16_apb_master.md
Name: vmicro16_apb_master

Overview:
- APB master bridge that converts a single-outstanding valid/ready request from a vmicro16 core into an APB SETUP/ACCESS transfer.
- Drives the interconnect toward the APB slave peripherals (BRAM, regs, GPIO, timer, BRAMex).
- Waits for PREADY and returns read data on a registered response port.
- A bounded wait-state timeout converts a hung slave (unmapped PSEL, stuck peripheral) into an error response, so the core never deadlocks.

Parameters:
- ADDR_WIDTH, 20: APB address width. Matches `APB_WIDTH, including the LWEX/SWEX/CORE_ID upper bits.
- DATA_WIDTH, 16: data bus width.
- TIMEOUT, 255: maximum ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- req_we  in  1  1 = write, 0 = read.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data. 0 for writes and for errors.
- rsp_err  out  1  qualifies rsp_valid. 1 = timeout abort.
- busy  out  1  transfer in progress (state != IDLE).
- M_PADDR  out  ADDR_WIDTH  APB address.
- M_PWRITE  out  1  APB write.
- M_PSELx  out  1  APB select.
- M_PENABLE  out  1  APB enable.
- M_PWDATA  out  DATA_WIDTH  APB write data.
- M_PRDATA  in  DATA_WIDTH  APB read data.
- M_PREADY  in  1  APB ready.

Behaviour:
- Reset (asserted low, asynchronous): state=IDLE, wait counter=0, all M_* outputs=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, latched request registers=0. Outputs go low immediately, not at the next edge.
- Reset mid-transfer: the transfer is abandoned and no response is ever issued for it.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered or decoded from state and latched registers only; no combinational path from req_* to M_*.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wdata and we; go to SETUP.
  - M_PSELx=M_PENABLE=0; M_PADDR, M_PWDATA and M_PWRITE driven 0.
- SETUP (exactly 1 cycle):
  - M_PSELx=1, M_PENABLE=0; M_PADDR, M_PWDATA and M_PWRITE come from the latched registers.
  - M_PREADY is ignored.
  - Next state is ACCESS; wait counter cleared.
- ACCESS:
  - M_PSELx=1, M_PENABLE=1; address, data and write are held stable from the SETUP values.
  - If M_PREADY=1: capture M_PRDATA into rsp_rdata for a read (0 for a write), set rsp_err=0, go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: abort. Set rsp_rdata=0, rsp_err=1, go to IDLE.
  - Else increment the counter and stay in ACCESS.
  - If M_PREADY and the timeout condition coincide, M_PREADY wins and the transfer succeeds.
- Response timing:
  - rsp_valid is high for exactly the first IDLE cycle after ACCESS, with rsp_err valid in the same cycle.
  - rsp_rdata holds its value until the next response.
- Latency: with zero wait states, accept edge at cycle 0, SETUP in cycle 1, ACCESS with PREADY in cycle 2, rsp_valid in cycle 3.
- Back-to-back: req_ready is high in the rsp_valid cycle. A request accepted there enters SETUP in the next cycle, giving a 3-cycle issue period. There is no queueing.
- After a timeout, M_PSELx and M_PENABLE drop in the rsp_valid cycle. A late PREADY in IDLE is ignored.
- Counter width is clog2(TIMEOUT+1) with a minimum of 1. The counter never wraps, because abort occurs first.
- req_* changes after acceptance have no effect on the transfer in flight.
- busy = (state != IDLE).

Test Plan:
- Zero-wait write: req addr=0x00012, wdata=0xBEEF, we=1.
  -> SETUP in cycle 1 with PSEL=1, EN=0, PADDR=0x00012, PWDATA=0xBEEF, PWRITE=1.
  -> ACCESS in cycle 2; rsp_valid in cycle 3 with err=0, rdata=0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234.
  -> PADDR/PWRITE stable throughout; rsp_valid 1 cycle later with rdata=0x1234, err=0.
- Timeout, TIMEOUT=4, PREADY held low.
  -> exactly 4 ACCESS cycles, then PSEL/EN low; rsp_valid with err=1, rdata=0.
  -> a PREADY pulse one cycle later causes no further response.
- Timeout boundary, TIMEOUT=4, PREADY=1 in the 4th ACCESS cycle with PRDATA=0x00AA.
  -> success: err=0, rdata=0x00AA.
- Back-to-back: req_valid held high with two reads (0x1, 0x2) and zero waits.
  -> second SETUP starts in cycle 4; responses in cycles 3 and 6; req_ready low in cycles 1-2 and 4-5.
- Reset mid-ACCESS: drive reset low during a wait state.
  -> PSEL/EN/PADDR go to 0 immediately and no rsp_valid is issued.
  -> after release, a new write completes normally.
